// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// mem_ctrl : byte-serial IF / load-store arbiter for one shared 8-bit sync RAM
// Revision : 1.0
// ============================================================================
module mem_ctrl #(
   parameter int RAM_ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req_i,
   input  logic [31:0]           if_addr_i,
   output logic                  if_done_o,
   output logic [31:0]           if_inst_o,
   input  logic [7:0]            mem_aluop_i,
   input  logic [31:0]           mem_addr_i,
   input  logic [31:0]           mem_wdata_i,
   output logic                  mem_done_o,
   output logic [31:0]           mem_rdata_o,
   output logic [RAM_ADDR_W-1:0] ram_addr_o,
   output logic [7:0]            ram_dout_o,
   output logic                  ram_wr_o,
   input  logic [7:0]            ram_din_i
);

   localparam logic [7:0] c_EXE_LB_OP  = 8'b1110_0000;
   localparam logic [7:0] c_EXE_LH_OP  = 8'b1110_0001;
   localparam logic [7:0] c_EXE_LW_OP  = 8'b1110_0011;
   localparam logic [7:0] c_EXE_LBU_OP = 8'b1110_0100;
   localparam logic [7:0] c_EXE_LHU_OP = 8'b1110_0101;
   localparam logic [7:0] c_EXE_SB_OP  = 8'b1110_1000;
   localparam logic [7:0] c_EXE_SH_OP  = 8'b1110_1001;
   localparam logic [7:0] c_EXE_SW_OP  = 8'b1110_1011;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      state_q;
   logic        src_mem_q;
   logic        wr_q;
   logic [31:0] base_q;
   logic [2:0]  n_q;
   logic [2:0]  k_q;
   logic [31:0] wdata_q;
   logic [31:0] data_q;

   logic        w_mem_req;
   logic        w_mem_store;
   logic [2:0]  w_mem_size;
   logic [2:0]  w_k_next;
   logic [1:0]  w_k_prev;
   logic [31:0] w_addr_next;
   logic [7:0]  w_wbyte_next;
   logic [31:0] w_data_d;

   always_comb begin
      w_mem_req   = 1'b1;
      w_mem_store = 1'b0;
      w_mem_size  = 3'd4;
      case (mem_aluop_i)
         c_EXE_LB_OP, c_EXE_LBU_OP: w_mem_size = 3'd1;
         c_EXE_LH_OP, c_EXE_LHU_OP: w_mem_size = 3'd2;
         c_EXE_LW_OP:               w_mem_size = 3'd4;
         c_EXE_SB_OP: begin
            w_mem_size  = 3'd1;
            w_mem_store = 1'b1;
         end
         c_EXE_SH_OP: begin
            w_mem_size  = 3'd2;
            w_mem_store = 1'b1;
         end
         c_EXE_SW_OP: begin
            w_mem_size  = 3'd4;
            w_mem_store = 1'b1;
         end
         default: w_mem_req = 1'b0;
      endcase
   end

   assign w_k_next     = k_q + 3'd1;
   assign w_k_prev     = 2'(k_q - 3'd1);
   assign w_addr_next  = base_q + 32'(w_k_next);
   assign w_wbyte_next = wdata_q[{w_k_next[1:0], 3'b000} +: 8];

   // Read data lags its address by one step, so step k delivers byte k-1.
   always_comb begin
      w_data_d = data_q;
      if (k_q != 3'd0) begin
         w_data_d[{w_k_prev, 3'b000} +: 8] = ram_din_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         src_mem_q   <= 1'b0;
         wr_q        <= 1'b0;
         base_q      <= 32'h0;
         n_q         <= 3'd0;
         k_q         <= 3'd0;
         wdata_q     <= 32'h0;
         data_q      <= 32'h0;
         if_done_o   <= 1'b0;
         if_inst_o   <= 32'h0;
         mem_done_o  <= 1'b0;
         mem_rdata_o <= 32'h0;
         ram_addr_o  <= '0;
         ram_dout_o  <= 8'h00;
         ram_wr_o    <= 1'b0;
      end else begin
         if_done_o  <= 1'b0;
         mem_done_o <= 1'b0;
         ram_wr_o   <= 1'b0;
         ram_addr_o <= '0;
         ram_dout_o <= 8'h00;
         case (state_q)
            S_IDLE: begin
               k_q    <= 3'd0;
               data_q <= 32'h0;
               if (w_mem_req) begin
                  src_mem_q  <= 1'b1;
                  wr_q       <= w_mem_store;
                  base_q     <= mem_addr_i;
                  n_q        <= w_mem_size;
                  wdata_q    <= mem_wdata_i;
                  state_q    <= S_BUSY;
                  ram_addr_o <= mem_addr_i[RAM_ADDR_W-1:0];
                  ram_wr_o   <= w_mem_store;
                  ram_dout_o <= w_mem_store ? mem_wdata_i[7:0] : 8'h00;
               end else if (if_req_i) begin
                  src_mem_q  <= 1'b0;
                  wr_q       <= 1'b0;
                  base_q     <= if_addr_i;
                  n_q        <= 3'd4;
                  wdata_q    <= 32'h0;
                  state_q    <= S_BUSY;
                  ram_addr_o <= if_addr_i[RAM_ADDR_W-1:0];
               end
            end
            S_BUSY: begin
               k_q <= w_k_next;
               if (wr_q) begin
                  if (w_k_next == n_q) begin
                     state_q    <= S_DONE;
                     mem_done_o <= 1'b1;
                  end else begin
                     ram_addr_o <= w_addr_next[RAM_ADDR_W-1:0];
                     ram_wr_o   <= 1'b1;
                     ram_dout_o <= w_wbyte_next;
                  end
               end else begin
                  if (k_q != 3'd0) begin
                     data_q <= w_data_d;
                  end
                  if (k_q == n_q) begin
                     state_q <= S_DONE;
                     if (src_mem_q) begin
                        mem_done_o  <= 1'b1;
                        mem_rdata_o <= w_data_d;
                     end else begin
                        if_done_o <= 1'b1;
                        if_inst_o <= w_data_d;
                     end
                  end else if (w_k_next != n_q) begin
                     ram_addr_o <= w_addr_next[RAM_ADDR_W-1:0];
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mem_ctrl : directed stimulus with a cycle-schedule reference model
// Revision    : 1.0
// ============================================================================
module tb_mem_ctrl;

   localparam logic [7:0] LB  = 8'b1110_0000;
   localparam logic [7:0] LH  = 8'b1110_0001;
   localparam logic [7:0] LW  = 8'b1110_0011;
   localparam logic [7:0] LHU = 8'b1110_0101;
   localparam logic [7:0] SB  = 8'b1110_1000;
   localparam logic [7:0] SH  = 8'b1110_1001;
   localparam logic [7:0] SW  = 8'b1110_1011;
   localparam logic [7:0] LBU = 8'b1110_0100;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        if_done;
   logic [31:0] if_inst;
   logic [7:0]  mem_aluop = 8'h00;
   logic [31:0] mem_addr = 32'h0;
   logic [31:0] mem_wdata = 32'h0;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic [31:0] ram_addr;
   logic [7:0]  ram_dout;
   logic        ram_wr;
   logic [7:0]  ram_din = 8'h00;

   always #5 clk = ~clk;

   mem_ctrl #(.RAM_ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_done_o(if_done), .if_inst_o(if_inst),
      .mem_aluop_i(mem_aluop), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
      .mem_done_o(mem_done), .mem_rdata_o(mem_rdata),
      .ram_addr_o(ram_addr), .ram_dout_o(ram_dout), .ram_wr_o(ram_wr), .ram_din_i(ram_din)
   );

   // Synchronous byte RAM, 1 KiB mirrored over the address space.
   logic [7:0] ram [0:1023] = '{default: 8'h00};
   always @(posedge clk) begin
      ram_din <= ram[ram_addr[9:0]];
      if (ram_wr) ram[ram_addr[9:0]] <= ram_dout;
   end

   // Reference: on acceptance, the whole transaction is laid out as a queue of
   // per-cycle expected bus states, ending in the done cycle and one idle cycle.
   typedef struct packed {
      logic [31:0] addr;
      logic        wr;
      logic [7:0]  dout;
      logic        ifd;
      logic        memd;
      logic        ld;
      logic [31:0] data;
   } step_t;

   step_t       q[$];
   step_t       cur;
   logic [7:0]  shadow [0:1023] = '{default: 8'h00};
   logic [31:0] exp_inst  = 32'h0;
   logic [31:0] exp_rdata = 32'h0;
   int          cyc_total = 0, cyc_bad = 0;
   int          dir_total = 0, dir_bad = 0;

   function automatic step_t mk(input logic [31:0] a, input logic w, input logic [7:0] d,
                                input logic fi, input logic fm, input logic l,
                                input logic [31:0] v);
      step_t s;
      s.addr = a; s.wr = w; s.dout = d; s.ifd = fi; s.memd = fm; s.ld = l; s.data = v;
      return s;
   endfunction

   task automatic cyc_cmp(input string name, input logic [31:0] act, input logic [31:0] want);
      cyc_total++;
      if (act !== want) begin
         cyc_bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, want);
      end
   endtask

   task automatic schedule();
      int          n;
      logic        st;
      logic        is_if;
      logic [31:0] base, wd, acc, a;
      n = 0; st = 1'b0; is_if = 1'b0;
      case (mem_aluop)
         LB, LBU: n = 1;
         LH, LHU: n = 2;
         LW:      n = 4;
         SB: begin n = 1; st = 1'b1; end
         SH: begin n = 2; st = 1'b1; end
         SW: begin n = 4; st = 1'b1; end
         default: n = 0;
      endcase
      base = mem_addr;
      wd   = mem_wdata;
      if (n == 0 && if_req) begin
         n = 4; is_if = 1'b1; base = if_addr;
      end
      if (n == 0) return;
      acc = 32'h0;
      for (int k = 0; k < n; k++) begin
         a = base + 32'(k);
         if (st) q.push_back(mk(a, 1'b1, wd[8*k +: 8], 1'b0, 1'b0, 1'b0, 32'h0));
         else begin
            q.push_back(mk(a, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0));
            acc[8*k +: 8] = shadow[a[9:0]];
         end
      end
      if (!st) q.push_back('0);
      q.push_back(mk(32'h0, 1'b0, 8'h00, is_if, !is_if, !st, acc));
      q.push_back('0);
   endtask

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         cur = '0;
         exp_inst = 32'h0;
         exp_rdata = 32'h0;
      end else begin
         cur = (q.size() > 0) ? q.pop_front() : step_t'('0);
         if (cur.wr) shadow[cur.addr[9:0]] = cur.dout;
         if (cur.ifd) exp_inst = cur.data;
         if (cur.memd && cur.ld) exp_rdata = cur.data;
      end
      cyc_cmp("ram_addr",  ram_addr,         cur.addr);
      cyc_cmp("ram_wr",    32'(ram_wr),      32'(cur.wr));
      cyc_cmp("ram_dout",  32'(ram_dout),    32'(cur.dout));
      cyc_cmp("if_done",   32'(if_done),     32'(cur.ifd));
      cyc_cmp("mem_done",  32'(mem_done),    32'(cur.memd));
      cyc_cmp("if_inst",   if_inst,          exp_inst);
      cyc_cmp("mem_rdata", mem_rdata,        exp_rdata);
      if (!rst && q.size() == 0) schedule();
   end

   task automatic dchk(input string name, input logic [31:0] act, input logic [31:0] want);
      dir_total++;
      if (act !== want) begin
         dir_bad++;
         $display("FAIL %s got=%h want=%h", name, act, want);
      end
   endtask

   // Issues one request in the next cycle (cycle 0) and returns the done latency.
   task automatic run(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                      input logic fetch, output int lat, output logic [31:0] res);
      @(posedge clk); #1;
      if (fetch) begin if_req = 1'b1; if_addr = a; end
      else begin mem_aluop = op; mem_addr = a; mem_wdata = wd; end
      lat = -1; res = 32'hx;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk); #1;
         if (if_done || mem_done) begin
            lat = c; res = fetch ? if_inst : mem_rdata;
            break;
         end
      end
      if_req = 1'b0; mem_aluop = 8'h00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat, mlat, ilat, pulses;
      logic [31:0] res, mres;

      @(posedge clk); #1;
      dchk("rst_ram_wr",  32'(ram_wr), 32'h0);
      dchk("rst_ram_addr", ram_addr,   32'h0);
      dchk("rst_if_inst",  if_inst,    32'h0);
      @(posedge clk); #2 rst = 1'b0;

      // Program the instruction word, then fetch it.
      run(SW, 32'h100, 32'h0010_0513, 1'b0, lat, res);
      dchk("sw_lat", 32'(lat), 32'd5);
      run(8'h00, 32'h100, 32'h0, 1'b1, lat, res);
      dchk("fetch_lat", 32'(lat), 32'd6);
      dchk("fetch_inst", res, 32'h0010_0513);

      run(SW, 32'h20, 32'hDEAD_BEEF, 1'b0, lat, res);
      dchk("sw2_lat", 32'(lat), 32'd5);
      dchk("sw2_bytes", {ram[35], ram[34], ram[33], ram[32]}, 32'hDEAD_BEEF);
      run(LH, 32'h20, 32'h0, 1'b0, lat, res);
      dchk("lh_lat", 32'(lat), 32'd4);
      dchk("lh_data", res, 32'h0000_BEEF);
      run(SB, 32'h21, 32'h0000_0080, 1'b0, lat, res);
      dchk("sb_lat", 32'(lat), 32'd2);
      run(LB, 32'h21, 32'h0, 1'b0, lat, res);
      dchk("lb_lat", 32'(lat), 32'd3);
      dchk("lb_data", res, 32'h0000_0080);
      run(LHU, 32'h22, 32'h0, 1'b0, lat, res);
      dchk("lhu_data", res, 32'h0000_DEAD);
      run(SH, 32'h30, 32'hFFFF_1234, 1'b0, lat, res);
      dchk("sh_lat", 32'(lat), 32'd3);
      dchk("sh_bytes", {16'h0, ram[49], ram[48]}, 32'h0000_1234);
      dchk("sh_rdata_held", mem_rdata, 32'h0000_DEAD);

      // Simultaneous IF and LW: load first, fetch starts in the idle cycle after.
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 32'h100; mem_aluop = LW; mem_addr = 32'h20;
      mlat = -1; ilat = -1; mres = 32'h0;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (mem_done) begin mlat = c; mres = mem_rdata; mem_aluop = 8'h00; end
         if (if_done) begin ilat = c; break; end
      end
      if_req = 1'b0; mem_aluop = 8'h00;
      dchk("arb_mem_lat", 32'(mlat), 32'd6);
      dchk("arb_mem_data", mres, 32'hDEAD_80EF);
      dchk("arb_if_lat", 32'(ilat), 32'd13);
      dchk("arb_if_inst", if_inst, 32'h0010_0513);

      // Reset in the middle of a word store after two bytes have been written.
      @(posedge clk); #1;
      mem_aluop = SW; mem_addr = 32'h40; mem_wdata = 32'hCAFE_F00D;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1; mem_aluop = 8'h00;
      #1;
      dchk("mrst_ram_wr",   32'(ram_wr),   32'h0);
      dchk("mrst_ram_addr", ram_addr,      32'h0);
      dchk("mrst_ram_dout", 32'(ram_dout), 32'h0);
      dchk("mrst_done",     32'({if_done, mem_done}), 32'h0);
      dchk("mrst_if_inst",  if_inst,       32'h0);
      dchk("mrst_rdata",    mem_rdata,     32'h0);
      @(posedge clk); #3 rst = 1'b0;
      dchk("mrst_bytes", {ram[67], ram[66], ram[65], ram[64]}, 32'h0000_F00D);
      run(LW, 32'h40, 32'h0, 1'b0, lat, res);
      dchk("mrst_lw", res, 32'h0000_F00D);

      // Wrapping address range, with the load request withdrawn mid-transfer.
      run(SW, 32'hFFFF_FFFE, 32'h1122_3344, 1'b0, lat, res);
      dchk("wrap_bytes", {ram[1], ram[0], ram[1023], ram[1022]}, 32'h1122_3344);
      @(posedge clk); #1;
      mem_aluop = LW; mem_addr = 32'hFFFF_FFFE;
      lat = -1; res = 32'h0; pulses = 0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c == 2) mem_aluop = 8'h00;
         if (mem_done) begin
            pulses++;
            if (lat < 0) begin lat = c; res = mem_rdata; end
         end
      end
      dchk("wrap_lat", 32'(lat), 32'd6);
      dchk("wrap_data", res, 32'h1122_3344);
      dchk("wrap_pulses", 32'(pulses), 32'd1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", cyc_total + dir_total, cyc_bad + dir_bad);
      $finish;
   end

endmodule
`default_nettype wire
